// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 latches operands, op and tag; S2 latches the result, status flags and tag.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [3:0]       s1_op_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] s2_result_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  logic             s2_zero_reg;
  logic             s2_neg_reg;
  logic             s2_carry_reg;
  logic             s2_ovf_reg;
  logic             s2_illegal_reg;

  logic adv2;
  logic accept;

  // in_ready looks only at pipeline occupancy and out_ready, never at in_valid.
  assign adv2     = s1_valid_reg && (!s2_valid_reg || out_ready);
  assign in_ready = !s1_valid_reg || adv2;
  assign accept   = in_valid && in_ready;

  logic [WIDTH-1:0] ai;
  logic [WIDTH-1:0] bi;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             ovf_raw;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_invert
    assign ai[gi] = s1_a_reg[gi] ^ s1_op_reg[3];
    assign bi[gi] = s1_b_reg[gi] ^ s1_op_reg[2];
  end

  // Bnegate doubles as the adder carry-in, so SUB/SLT form a + ~b + 1.
  assign {carry_out, sum} = {1'b0, ai} + {1'b0, bi} + {{WIDTH{1'b0}}, s1_op_reg[2]};
  assign ovf_raw = (ai[WIDTH-1] == bi[WIDTH-1]) && (sum[WIDTH-1] != ai[WIDTH-1]);

  logic [WIDTH-1:0] result_next;
  logic             is_arith_next;
  logic             legal_next;
  logic             zero_next;
  logic             neg_next;
  logic             carry_next;
  logic             ovf_next;

  always_comb begin
    result_next   = '0;
    is_arith_next = 1'b0;
    legal_next    = 1'b1;
    case (s1_op_reg)
      OP_AND, OP_NOR: result_next = ai & bi;
      OP_OR, OP_NAND: result_next = ai | bi;
      OP_ADD, OP_SUB: begin
        result_next   = sum;
        is_arith_next = 1'b1;
      end
      OP_SLT: begin
        result_next   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
        is_arith_next = 1'b1;
      end
      default: legal_next = 1'b0;
    endcase
    zero_next  = legal_next && (result_next == '0);
    neg_next   = result_next[WIDTH-1];
    carry_next = is_arith_next && carry_out;
    ovf_next   = is_arith_next && ovf_raw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_a_reg       <= '0;
      s1_b_reg       <= '0;
      s1_op_reg      <= '0;
      s1_tag_reg     <= '0;
      s2_valid_reg   <= 1'b0;
      s2_result_reg  <= '0;
      s2_tag_reg     <= '0;
      s2_zero_reg    <= 1'b0;
      s2_neg_reg     <= 1'b0;
      s2_carry_reg   <= 1'b0;
      s2_ovf_reg     <= 1'b0;
      s2_illegal_reg <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_a_reg     <= in_a;
        s1_b_reg     <= in_b;
        s1_op_reg    <= in_op;
        s1_tag_reg   <= in_tag;
      end else if (adv2) begin
        s1_valid_reg <= 1'b0;
      end

      if (adv2) begin
        s2_valid_reg   <= 1'b1;
        s2_result_reg  <= result_next;
        s2_tag_reg     <= s1_tag_reg;
        s2_zero_reg    <= zero_next;
        s2_neg_reg     <= neg_next;
        s2_carry_reg   <= carry_next;
        s2_ovf_reg     <= ovf_next;
        s2_illegal_reg <= !legal_next;
      end else if (out_ready) begin
        s2_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid   = s2_valid_reg;
  assign out_result  = s2_result_reg;
  assign out_tag     = s2_tag_reg;
  assign out_zero    = s2_zero_reg;
  assign out_neg     = s2_neg_reg;
  assign out_carry   = s2_carry_reg;
  assign out_ovf     = s2_ovf_reg;
  assign out_illegal = s2_illegal_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, stall/stream, reset flush
// and randomized traffic against an arithmetic reference model and result queue.
module tb_alu_pipe;
  localparam int W = 32;
  localparam int T = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_op;
  logic [T-1:0] in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [T-1:0] out_tag;
  logic         out_zero;
  logic         out_neg;
  logic         out_carry;
  logic         out_ovf;
  logic         out_illegal;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
    .out_ovf(out_ovf), .out_illegal(out_illegal)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs of accepted-but-not-yet-delivered operations, oldest first.
  logic [41:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [42:0] prev_out;
  logic        snap_valid;
  logic        snap_acc;
  logic [41:0] snap_vec;

  function automatic logic [41:0] mk(logic [31:0] r, logic [4:0] tg, logic z, logic n,
                                     logic c, logic v, logic il);
    return {r, tg, z, n, c, v, il};
  endfunction

  function automatic logic [41:0] model(logic [31:0] a, logic [31:0] b, logic [3:0] op,
                                        logic [4:0] tg);
    logic [31:0] r;
    logic [32:0] wide;
    logic        c, v, il;
    longint      sa, sb, s;
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2: begin
        r = a + b;
        wide = {1'b0, a} + {1'b0, b};
        c = wide[32];
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6, 4'd7: begin
        r = (op == 4'd6) ? a - b : ((sa < sb) ? 32'd1 : 32'd0);
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd12: r = ~(a | b);
      4'd13: r = ~(a & b);
      default: il = 1'b1;
    endcase
    return mk(r, tg, !il && (r == 32'd0), r[31], c, v, il);
  endfunction

  function automatic logic [41:0] dut_vec();
    return {out_result, out_tag, out_zero, out_neg, out_carry, out_ovf, out_illegal};
  endfunction

  task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, score handshakes, return 1 ns after the rising edge.
  task automatic step();
    logic [41:0] e;
    @(negedge clk);
    if (prev_stall) check("stall_hold", {out_valid, dut_vec()}, prev_out);
    check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_valid, dut_vec()};
    snap_valid = out_valid;
    snap_acc   = in_valid && in_ready;
    snap_vec   = dut_vec();
    if (out_valid && out_ready) begin
      check("result_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", dut_vec(), e);
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_op, in_tag));
    $display("t=%0t acc=%0d a=%h b=%h op=%h tag=%0d | out_v=%0d rdy=%0d res=%h tag=%0d",
             $time, snap_acc, in_a, in_b, in_op, in_tag, out_valid, out_ready,
             out_result, out_tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(string name);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    check({name, "_outputs"}, {out_valid, dut_vec()}, 43'd0);
    check({name, "_in_ready"}, in_ready, 1);
  endtask

  task automatic directed(string name, logic [31:0] a, logic [31:0] b, logic [3:0] op,
                          logic [4:0] tg, logic [41:0] want);
    int n;
    in_a = a; in_b = b; in_op = op; in_tag = tg;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n = 0;
    do begin step(); n++; end while (!snap_acc && n < 20);
    in_valid = 1'b0;
    check({name, "_accept"}, snap_acc, 1);
    n = 0;
    do begin step(); n++; end while (!snap_valid && n < 20);
    check({name, "_latency"}, n, 2);
    check({name, "_value"}, snap_vec, want);
  endtask

  task automatic drain(string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin step(); n++; end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  logic [3:0] legal_ops[7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13};

  initial begin
    int acc;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_reset("reset");

    directed("add_ovf",  32'h7FFFFFFF, 32'h1, 4'b0010, 5'd3, mk(32'h80000000, 5'd3, 0, 1, 0, 1, 0));
    directed("sub_zero", 32'd5, 32'd5, 4'b0110, 5'd1, mk(32'd0, 5'd1, 1, 0, 1, 0, 0));
    directed("slt_neg",  32'hFFFFFFFF, 32'd1, 4'b0111, 5'd2, mk(32'd1, 5'd2, 0, 0, 1, 0, 0));
    directed("slt_pos",  32'd1, 32'hFFFFFFFF, 4'b0111, 5'd4, mk(32'd0, 5'd4, 1, 0, 0, 0, 0));
    directed("and",  32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 5'd5, mk(32'hF000F000, 5'd5, 0, 1, 0, 0, 0));
    directed("or",   32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 5'd6, mk(32'hFFF0FFF0, 5'd6, 0, 1, 0, 0, 0));
    directed("nor",  32'hF0F0F0F0, 32'hFF00FF00, 4'b1100, 5'd8, mk(32'h000F000F, 5'd8, 0, 0, 0, 0, 0));
    directed("nand", 32'hF0F0F0F0, 32'hFF00FF00, 4'b1101, 5'd9, mk(32'h0FFF0FFF, 5'd9, 0, 0, 0, 0, 0));
    directed("illegal", 32'h7FFFFFFF, 32'h1, 4'b0011, 5'd7, mk(32'd0, 5'd7, 0, 0, 0, 0, 1));
    drain("directed");

    // Eight ADDs streamed while the consumer stalls for four cycles.
    acc = 0;
    in_a = $urandom; in_b = $urandom; in_op = 4'b0010; in_tag = 5'd0;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && acc < 8; k++) begin
      out_ready = !(k >= 3 && k <= 6);
      step();
      if (snap_acc) begin
        acc++;
        in_a = $urandom; in_b = $urandom; in_tag = 5'(acc);
      end
    end
    check("stream_accepts", acc, 8);
    drain("stream");

    // Reset with two operations in flight; neither may ever surface.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op = 4'b0010; in_a = 32'd100; in_b = 32'd200; in_tag = 5'd30;
    step();
    in_tag = 5'd31;
    step();
    do_reset("flush");
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("flush_no_output", snap_valid, 0);
    end

    // Randomized traffic with random back-pressure, including illegal encodings.
    for (int k = 0; k < 300; k++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_a   = $urandom;
      in_b   = ($urandom_range(0, 4) == 0) ? in_a : $urandom;
      in_op  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 6)];
      in_tag = 5'($urandom);
      step();
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised WIDTH-bit ALU; successor to the bit-slice ALU, keeping the same 4-bit Operation encoding.
- Adds a 2-stage registered pipeline with valid/ready handshakes on both sides, status flags, illegal-op detection and a tag passed alongside each result.
- Sits between the ID/EX operand latch and the EX/MEM register of the pipelined CPU.
- Sustains one operation per cycle when the consumer does not stall.

Parameters:
- WIDTH, 32, operand and result width in bits (≥2).
- TAG_W, 5, width of the opaque tag carried with each operation (e.g. destination register index).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block accepts the operation this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  4  Operation[3:0] = {Ainvert, Bnegate, op[1:0]}.
- in_tag  input  TAG_W  tag, returned unchanged with the result.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  result.
- out_tag  output  TAG_W  tag of this result.
- out_zero  output  1  out_result == 0.
- out_neg  output  1  out_result[WIDTH-1].
- out_carry  output  1  adder carry-out.
- out_ovf  output  1  signed overflow.
- out_illegal  output  1  in_op was not a legal encoding.

Behaviour:
- Reset: one clock with rst_n = 0 on a rising edge clears both stage valid bits. All outputs read 0 during reset and on the cycle after it; in_ready reads 1 on that cycle.
- Reset mid-operation: all in-flight operations are discarded and are never presented.
- Stage 1 (S1): registers a, b, op and tag on the cycle where in_valid && in_ready.
- Stage 2 (S2): registers the result, flags and tag.
- Pipeline advance:
  - adv2 = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || adv2. This is combinational from out_ready, with no path from in_valid.
- Latency: an operation accepted in cycle n gives out_valid in cycle n+2 if out_ready was held high.
- Throughput: back-to-back accepts give back-to-back results.
- Stall: while out_valid && !out_ready, all of the following hold until the handshake completes:
  - out_* are held stable.
  - S1 holds its operation.
  - in_ready falls once S1 is occupied.
- Datapath (in S1→S2 logic):
  - Ai = Op[3] ? ~a : a.
  - Bi = Op[2] ? ~b : b.
  - Adder sum = Ai + Bi + Op[2], so carry-in = Bnegate.
- Legal encodings:
  - 0000 AND: Ai&Bi.
  - 0001 OR: Ai|Bi.
  - 0010 ADD: sum.
  - 0110 SUB: sum.
  - 0111 SLT: result = {WIDTH-1 zeros, sum[MSB] ^ ovf}, signed compare.
  - 1100 NOR: ~a&~b.
  - 1101 NAND: ~a|~b.
- Any other in_op:
  - out_result = 0, out_illegal = 1, and all other flags = 0.
  - The tag is still returned and the handshake completes normally. There is no simulation print.
- Flags:
  - out_carry = adder carry-out for ADD/SUB/SLT, else 0.
  - out_ovf = (Ai[MSB] == Bi[MSB]) && (sum[MSB] != Ai[MSB]) for ADD/SUB/SLT, else 0.
  - out_zero and out_neg are evaluated on the final out_result.
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- Simultaneous accept and release in the same cycle is legal, as is a full pipeline plus out_ready rising: there is no bubble and no duplication.
- in_valid may drop without being accepted; no operation is captured.

Test Plan:
- WIDTH=32: ADD a=0x7FFFFFFF, b=1, tag=3, out_ready=1 → 2 cycles later result=0x80000000, ovf=1, neg=1, carry=0, tag=3.
- SUB a=5, b=5 → result=0, zero=1, carry=1, ovf=0. SLT a=0xFFFFFFFF (−1), b=1 → result=1. SLT a=1, b=0xFFFFFFFF → result=0.
- AND/OR/NOR/NAND with a=0xF0F0F0F0, b=0xFF00FF00 → 0xF000F000, 0xFFF0FFF0, 0x000F000F, 0x0FFF0FFF respectively.
- Illegal op 0011, tag=7 → result=0, illegal=1, all other flags 0, tag=7 returned.
- Stream of 8 ADDs with in_valid=1, while out_ready is held low for cycles 3–6:
  - in_ready falls after 2 accepts.
  - Outputs stay stable during the stall.
  - All 8 results arrive in order with no loss or duplicate.
  - Full throughput resumes once out_ready returns high.
- rst_n=0 for one cycle while 2 operations are in flight → next cycle out_valid=0 and in_ready=1; neither discarded result ever appears.
